// File: rtl/core_readout_pkg.sv
// rtl/core_readout_pkg.sv - shared types and word-layout helpers for the core region readout
package core_readout_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_SCAN = 2'd1,
        RD_EOE  = 2'd2
    } rd_state_e;

    localparam logic RR_FIXED = 1'b0;
    localparam logic RR_ROUND = 1'b1;

    // Output word layout, LSB first: ToT (NPIX*TOT_W), RegAddr (RA_W), TrigId (TRIG_W), Eoe (1)
    function automatic int addr_lsb(input int npix, input int tot_w);
        return npix * tot_w;
    endfunction

    function automatic int trig_lsb(input int ra_w, input int npix, input int tot_w);
        return ra_w + addr_lsb(npix, tot_w);
    endfunction

    function automatic int eoe_bit(input int trig_w, input int ra_w, input int npix, input int tot_w);
        return trig_w + trig_lsb(ra_w, npix, tot_w);
    endfunction

endpackage

// File: rtl/core_readout_fifo.sv
// rtl/core_readout_fifo.sv - synchronous output FIFO with head taken straight from storage registers
module core_readout_fifo
    import core_readout_pkg::*;
#(
    parameter int DW    = 26,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    output logic          o_full,
    input  logic          i_pop,
    output logic          o_empty,
    output logic [DW-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Full is judged on the current occupancy, so a pop never makes room for a same-cycle push
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage, pointers and occupancy; memory is cleared so the head reads zero out of reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_region_readout_arbiter.sv
// rtl/core_region_readout_arbiter.sv - snapshot arbiter packing pending regions into tagged FIFO words
module core_region_readout_arbiter
    import core_readout_pkg::*;
#(
    parameter int NREG       = 16,
    parameter int NPIX       = 4,
    parameter int TOT_W      = 4,
    parameter int TRIG_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic                                           i_rr_mode,
    input  logic                                           i_read_req,
    input  logic [TRIG_W-1:0]                              i_trig_id,
    input  logic [NREG-1:0]                                i_reg_req,
    input  logic [NREG*NPIX*TOT_W-1:0]                     i_reg_data,
    output logic [NREG-1:0]                                o_reg_grant,
    output logic                                           o_busy,
    output logic                                           o_out_valid,
    input  logic                                           i_out_ready,
    output logic [1+TRIG_W+$clog2(NREG)+NPIX*TOT_W-1:0]    o_out_data
);

    localparam int RA_W     = $clog2(NREG);
    localparam int RW       = NPIX * TOT_W;
    localparam int DW       = 1 + TRIG_W + RA_W + RW;
    localparam int ADDR_LSB = addr_lsb(NPIX, TOT_W);
    localparam int TRIG_LSB = trig_lsb(RA_W, NPIX, TOT_W);
    localparam int EOE_BIT  = eoe_bit(TRIG_W, RA_W, NPIX, TOT_W);

    rd_state_e         r_state;
    rd_state_e         w_state_next;
    logic [NREG-1:0]   r_pend;
    logic [TRIG_W-1:0] r_trig;
    logic [RA_W-1:0]   r_ptr;

    logic [RA_W-1:0]   w_winner;
    logic [NREG-1:0]   w_onehot;
    logic [NREG-1:0]   w_pend_left;
    logic [RA_W-1:0]   w_ptr_next;
    logic [RW-1:0]     w_win_data;
    logic              w_grant_fire;
    logic              w_push;
    logic [DW-1:0]     w_push_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // Lowest set index wins
    function automatic logic [RA_W-1:0] pick_fixed(input logic [NREG-1:0] req);
        logic [RA_W-1:0] win;
        win = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (req[i]) win = RA_W'(i);
        end
        return win;
    endfunction

    // First set index at or above ptr, wrapping past the top region back to region 0
    function automatic logic [RA_W-1:0] pick_rotate(input logic [NREG-1:0] req, input logic [RA_W-1:0] ptr);
        logic [RA_W-1:0] win;
        logic            found;
        int              idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREG) idx = idx - NREG;
            if (!found && req[idx]) begin
                win   = RA_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_winner     = (i_rr_mode == RR_ROUND) ? pick_rotate(r_pend, r_ptr) : pick_fixed(r_pend);
    assign w_onehot     = NREG'(1) << w_winner;
    assign w_pend_left  = r_pend & ~w_onehot;
    assign w_ptr_next   = (w_winner == RA_W'(NREG - 1)) ? '0 : w_winner + 1'b1;
    assign w_win_data   = i_reg_data[int'(w_winner) * RW +: RW];
    assign w_grant_fire = (r_state == RD_SCAN) && (r_pend != '0) && !w_fifo_full;
    assign o_busy       = (r_state != RD_IDLE);
    assign o_out_valid  = !w_fifo_empty;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; the last grant moves straight to EOE so the end word follows without a gap
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RD_IDLE: if (i_read_req) w_state_next = RD_SCAN;
            RD_SCAN: begin
                if (r_pend == '0) begin
                    w_state_next = RD_EOE;
                end else if (w_grant_fire && (w_pend_left == '0)) begin
                    w_state_next = RD_EOE;
                end
            end
            RD_EOE:  if (!w_fifo_full) w_state_next = RD_IDLE;
            default: w_state_next = RD_IDLE;
        endcase
    end

    // Grant strobe and FIFO push word for the current state
    always_comb begin
        o_reg_grant = '0;
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            RD_SCAN: begin
                if (w_grant_fire) begin
                    o_reg_grant                       = w_onehot;
                    w_push                            = 1'b1;
                    w_push_data[TRIG_LSB +: TRIG_W]   = r_trig;
                    w_push_data[ADDR_LSB +: RA_W]     = w_winner;
                    w_push_data[0 +: RW]              = w_win_data;
                end
            end
            RD_EOE: begin
                if (!w_fifo_full) begin
                    w_push                            = 1'b1;
                    w_push_data[EOE_BIT]              = 1'b1;
                    w_push_data[TRIG_LSB +: TRIG_W]   = r_trig;
                end
            end
            default: ;
        endcase
    end

    // Event snapshot on request, pending-bit retirement and round-robin pointer on each grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            r_trig <= '0;
            r_ptr  <= '0;
        end else if ((r_state == RD_IDLE) && i_read_req) begin
            r_pend <= i_reg_req;
            r_trig <= i_trig_id;
        end else if (w_grant_fire) begin
            r_pend <= w_pend_left;
            r_ptr  <= w_ptr_next;
        end
    end

    core_readout_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .o_full      (w_fifo_full),
        .i_pop       (i_out_ready),
        .o_empty     (w_fifo_empty),
        .o_head      (o_out_data)
    );

endmodule
